// File: rtl/load_store_unit_if.sv
// Memory-stage request/response bundle plus the word-addressed data memory port.
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_rdata,
        output ready, done, err, rdata, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_rdata,
        input  ready, done, err, rdata, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store front end: byte/half/word accesses onto a word-addressed
// async memory, read-modify-write for sub-word stores, misaligned requests flagged.
module load_store_unit (
    input  logic                  clk,
    input  logic                  rst_n,
    load_store_unit_if.slave      bus
);
    localparam int unsigned DW = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t          state;
    state_t          state_next;

    logic            we_q;
    logic [1:0]      size_q;
    logic            sign_q;
    logic [1:0]      lane_q;
    logic [15:0]     wdata_q;
    logic            err_q;
    logic [DW-1:0]   rdata_q;
    logic [DW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;

    logic            accept_c;
    logic            bad_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;
    logic [DW-1:0]   merged_c;
    logic [DW-1:0]   loaded_c;

    assign accept_c = (state == IDLE) && bus.req;
    assign bad_c    = (bus.size == SZ_ILL)
                   || ((bus.size == SZ_HALF) && bus.addr[0])
                   || ((bus.size == SZ_WORD) && (bus.addr[1:0] != 2'b00));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (bad_c)                      state_next = DONE;
                    else if (!bus.we)               state_next = READ;
                    else if (bus.size == SZ_WORD)   state_next = WRITE;
                    else                            state_next = READ;
                end
            end
            READ:  state_next = we_q ? WRITE : DONE;
            WRITE: state_next = DONE;
            DONE:  state_next = IDLE;
        endcase
    end

    // Handshake and write strobe decoded from state only
    always_comb begin
        bus.ready     = 1'b0;
        bus.done      = 1'b0;
        bus.mem_write = 1'b0;
        case (state)
            IDLE:  bus.ready     = 1'b1;
            WRITE: bus.mem_write = 1'b1;
            DONE:  bus.done      = 1'b1;
            default: ;
        endcase
    end

    // Lane extraction and merge against the word currently read
    always_comb begin
        byte_c   = bus.mem_rdata[{lane_q, 3'b000} +: 8];
        half_c   = bus.mem_rdata[{lane_q[1], 4'b0000} +: 16];
        merged_c = bus.mem_rdata;
        loaded_c = bus.mem_rdata;
        if (size_q == SZ_BYTE) begin
            merged_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            loaded_c = {{24{sign_q & byte_c[7]}}, byte_c};
        end else if (size_q == SZ_HALF) begin
            merged_c[{lane_q[1], 4'b0000} +: 16] = wdata_q;
            loaded_c = {{16{sign_q & half_c[15]}}, half_c};
        end
    end

    // Request latch and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            sign_q      <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (accept_c) begin
            we_q        <= bus.we;
            size_q      <= bus.size;
            sign_q      <= bus.sign_ext;
            lane_q      <= bus.addr[1:0];
            wdata_q     <= bus.wdata[15:0];
            err_q       <= bad_c;
            rdata_q     <= '0;
            mem_addr_q  <= {bus.addr[31:2], 2'b00};
            if (!bad_c && bus.we && (bus.size == SZ_WORD)) mem_wdata_q <= bus.wdata;
        end else if (state == READ) begin
            if (we_q) mem_wdata_q <= merged_c;
            else      rdata_q     <= loaded_c;
        end
    end

    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
